// File: rtl/decoder_arbiter.sv
// rtl/decoder_arbiter.sv - round-robin arbiter driving a 2-to-4 decoder's addr0/addr1/enable
//
// Optional feature macro: ARB_TIMEOUT_EN (forced release after HOLD_MAX cycles of grant).
// With the macro undefined there is no hold counter and timeout is tied to 0.

module decoder_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic       addr0,
  output logic       addr1,
  output logic       enable,
  output logic [3:0] grant,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Last count value before a forced release; enable is then high for HOLD_MAX cycles.
  localparam logic [7:0] HOLD_MAX_M1 = 8'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [1:0] addr_q,  addr_d;
  logic       enable_q, enable_d;
  logic [3:0] grant_q, grant_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic       normal_release;
  logic       forced_release;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q,  timeout_d;
`endif

  // Round-robin search: first set request starting at ptr and wrapping mod 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!win_found && req[ptr_q + 2'(i)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(i);
      end
    end
  end

  // Release conditions while a grant is active; done and owner drop merge into one release.
  always_comb begin
    normal_release = done || !req[addr_q];
`ifdef ARB_TIMEOUT_EN
    forced_release = !normal_release && (hold_cnt_q == HOLD_MAX_M1);
`else
    forced_release = 1'b0;
`endif
  end

  // Next-state and registered-output computation for the IDLE/GRANT machine.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    addr_d   = addr_q;
    enable_d = enable_q;
    grant_d  = grant_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        grant_d  = 4'b0000;
        if (win_found) begin
          // Select bits only move here, while enable is still low.
          addr_d   = win_idx;
          enable_d = 1'b1;
          grant_d  = 4'b0001 << win_idx;
          state_d  = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (normal_release || forced_release) begin
          // Going back to IDLE guarantees at least one bubble cycle before the next grant.
          enable_d = 1'b0;
          grant_d  = 4'b0000;
          ptr_d    = addr_q + 2'd1;
          state_d  = IDLE;
`ifdef ARB_TIMEOUT_EN
          timeout_d = forced_release;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
        grant_d  = 4'b0000;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      addr_q   <= 2'd0;
      enable_q <= 1'b0;
      grant_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      enable_q <= enable_d;
      grant_q  <= grant_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_hold_max;
  assign unused_hold_max = ^HOLD_MAX_M1;
  assign timeout         = 1'b0;
`endif

  assign addr0  = addr_q[0];
  assign addr1  = addr_q[1];
  assign enable = enable_q;
  assign grant  = grant_q;

endmodule

// File: tb/tb_decoder_arbiter.sv
// tb/tb_decoder_arbiter.sv - directed self-checking bench for decoder_arbiter

module tb_decoder_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic       addr0;
  logic       addr1;
  logic       enable;
  logic [3:0] grant;
  logic       timeout;

  int n_checks = 0;
  int n_fails  = 0;

  decoder_arbiter #(.HOLD_MAX(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .done   (done),
    .addr0  (addr0),
    .addr1  (addr1),
    .enable (enable),
    .grant  (grant),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Advance one edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Full output check: addr {addr1,addr0}, enable, grant, timeout.
  task automatic check_all(input string tag, input logic [1:0] e_addr, input logic e_en,
                           input logic [3:0] e_grant, input logic e_to);
    check({tag, ".addr"},    {2'b00, addr1, addr0}, {2'b00, e_addr});
    check({tag, ".enable"},  {3'b000, enable}, {3'b000, e_en});
    check({tag, ".grant"},   grant, e_grant);
    check({tag, ".timeout"}, {3'b000, timeout}, {3'b000, e_to});
  endtask

  logic [3:0] rr_order [5];

  initial begin
    rr_order[0] = 4'b0001;
    rr_order[1] = 4'b0010;
    rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000;
    rr_order[4] = 4'b0001;

    // Reset with all requests asserted.
    reset = 1'b1; req = 4'b1111; done = 1'b0;
    step();
    check_all("reset1", 2'b00, 1'b0, 4'b0000, 1'b0);
    step();
    check_all("reset2", 2'b00, 1'b0, 4'b0000, 1'b0);

    // Single request from reset.
    reset = 1'b0; req = 4'b0100;
    step();
    check_all("grant2", 2'b10, 1'b1, 4'b0100, 1'b0);
    done = 1'b1;
    step();
    check_all("rel2", 2'b10, 1'b0, 4'b0000, 1'b0);
    done = 1'b0; req = 4'b0000;
    step();
    check_all("idle_noreq", 2'b10, 1'b0, 4'b0000, 1'b0);

    // Rotation with all requests held, from ptr=0.
    reset = 1'b1;
    step();
    reset = 1'b0; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("rr_grant%0d", k), grant, rr_order[k]);
      check($sformatf("rr_en%0d", k), {3'b000, enable}, 4'b0001);
      done = 1'b1;
      step();
      check($sformatf("rr_bubble%0d", k), {3'b000, enable}, 4'b0000);
      done = 1'b0;
    end
    // Last release was owner 0 (ptr=1); grant and release owner 1 to reach ptr=2.
    step();
    check_all("own1", 2'b01, 1'b1, 4'b0010, 1'b0);
    done = 1'b1;
    step();
    check_all("own1_rel", 2'b01, 1'b0, 4'b0000, 1'b0);

    // Wrap search past 2 and 3.
    done = 1'b0; req = 4'b0011;
    step();
    check_all("wrap0", 2'b00, 1'b1, 4'b0001, 1'b0);
    req = 4'b0010;
    step();
    check_all("drop0", 2'b00, 1'b0, 4'b0000, 1'b0);
    step();
    check_all("after_drop", 2'b01, 1'b1, 4'b0010, 1'b0);
    done = 1'b1;
    step();
    check_all("rel1b", 2'b01, 1'b0, 4'b0000, 1'b0);

    // Owner 2 with req[3] toggling during the grant.
    done = 1'b0; req = 4'b0100;
    step();
    check_all("own2", 2'b10, 1'b1, 4'b0100, 1'b0);
    req = 4'b1100;
    step();
    check_all("tog_a", 2'b10, 1'b1, 4'b0100, 1'b0);
    req = 4'b0100;
    step();
    check_all("tog_b", 2'b10, 1'b1, 4'b0100, 1'b0);
    req = 4'b1100;
    step();
    check_all("tog_c", 2'b10, 1'b1, 4'b0100, 1'b0);

    // Simultaneous done and owner drop, then done in IDLE is ignored.
    req = 4'b1000; done = 1'b1;
    step();
    check_all("dual_rel", 2'b10, 1'b0, 4'b0000, 1'b0);
    req = 4'b0000;
    step();
    check_all("done_idle", 2'b10, 1'b0, 4'b0000, 1'b0);
    done = 1'b0;

    // Long hold of requester 3 (ptr=3).
    req = 4'b1000;
    step();
    check_all("hold_g", 2'b11, 1'b1, 4'b1000, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      check_all($sformatf("hold%0d", k), 2'b11, 1'b1, 4'b1000, 1'b0);
    end
    step();
    check_all("forced_rel", 2'b11, 1'b0, 4'b0000, 1'b1);
    step();
    check_all("regrant", 2'b11, 1'b1, 4'b1000, 1'b0);
    step();
    step();
    step();
    done = 1'b1;
    step();
    check_all("rel_prio", 2'b11, 1'b0, 4'b0000, 1'b0);
    done = 1'b0;
`else
    for (int k = 0; k < 55; k++) begin
      step();
      check_all($sformatf("hold%0d", k), 2'b11, 1'b1, 4'b1000, 1'b0);
    end
    reset = 1'b1;
    step();
    check_all("reset_mid", 2'b00, 1'b0, 4'b0000, 1'b0);
    reset = 1'b0;
`endif

    req = 4'b0000;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
